// File: rtl/test_hu_hls_deadlock_report_unit.sv
// test_hu_hls_deadlock_report_unit
// Central deadlock collector for one HLS dataflow region. On the first
// detection it broadcasts dl_detect_in, injects the origin token, follows the
// token around the dependency cycle, clears it when the loop closes (or the
// trace is abandoned), and streams the ordered list of process IDs out.
// Ports:
//   clock, reset           - rising-edge clock, asynchronous active-low reset
//   dl_detect_vec          - detect outputs of all detection units
//   proc_token_vec         - token present at each process
//   dl_detect_in           - sticky broadcast detect flag
//   origin_vec             - one-cycle one-hot origin pulse
//   token_clear_vec        - one-cycle all-ones token clear pulse
//   deadlock               - sticky deadlock flag
//   trace_closed           - 1 = token came back to origin, 0 = aborted trace
//   rpt_valid/ready/data/last - valid/ready report stream of process IDs
module test_hu_hls_deadlock_report_unit #(
    parameter int PROC_NUM = 4,
    parameter int ID_W     = 2,
    parameter int TIMEOUT  = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [PROC_NUM-1:0] dl_detect_vec,
    input  logic [PROC_NUM-1:0] proc_token_vec,
    output logic                dl_detect_in,
    output logic [PROC_NUM-1:0] origin_vec,
    output logic [PROC_NUM-1:0] token_clear_vec,
    output logic                deadlock,
    output logic                trace_closed,
    output logic                rpt_valid,
    input  logic                rpt_ready,
    output logic [ID_W-1:0]     rpt_data,
    output logic                rpt_last
);

    localparam int LEN_W = $clog2(PROC_NUM + 1);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam int BUF_N = 1 << ID_W;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ORIGIN = 3'd1;
    localparam logic [2:0] ST_TRACE  = 3'd2;
    localparam logic [2:0] ST_REPORT = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    // Index of the lowest set bit (0 when none is set).
    function automatic logic [ID_W-1:0] lowest_idx(input logic [PROC_NUM-1:0] v);
        lowest_idx = {ID_W{1'b0}};
        for (int i = PROC_NUM - 1; i >= 0; i--) begin
            if (v[i]) begin
                lowest_idx = ID_W'(i);
            end
        end
    endfunction

    // One-hot decode of a process ID into a PROC_NUM-wide mask.
    function automatic logic [PROC_NUM-1:0] onehot(input logic [ID_W-1:0] idx);
        onehot = {PROC_NUM{1'b0}};
        for (int i = 0; i < PROC_NUM; i++) begin
            onehot[i] = (ID_W'(i) == idx);
        end
    endfunction

    logic [2:0]          state_r;
    logic [ID_W-1:0]     trace_r [BUF_N];
    logic [LEN_W-1:0]    len_r;
    logic [LEN_W-1:0]    ptr_r;
    logic [PROC_NUM-1:0] visited_r;
    logic [ID_W-1:0]     origin_r;
    logic [CNT_W-1:0]    tcnt_r;
    logic                first_r;

    logic [PROC_NUM-1:0] new_s;
    logic [ID_W-1:0]     new_idx_s;
    logic                fin_s;
    logic                fin_closed_s;
    logic                app_s;
    logic                tick_s;

    // Decide what the TRACE state does this cycle: close, abort, append or count idle.
    always_comb begin
        new_s        = proc_token_vec & ~visited_r;
        new_idx_s    = lowest_idx(new_s);
        fin_s        = 1'b0;
        fin_closed_s = 1'b0;
        app_s        = 1'b0;
        tick_s       = 1'b0;
        // The origin bit is already visited, so in the first TRACE cycle a
        // token still sitting at the origin neither closes nor appends.
        if (((proc_token_vec & onehot(origin_r)) != {PROC_NUM{1'b0}}) && !first_r) begin
            fin_s        = 1'b1;
            fin_closed_s = 1'b1;
        end else if (new_s != {PROC_NUM{1'b0}}) begin
            if (len_r == LEN_W'(PROC_NUM)) begin
                fin_s = 1'b1;
            end else begin
                app_s = 1'b1;
            end
        end else if (proc_token_vec == {PROC_NUM{1'b0}}) begin
            if (tcnt_r == CNT_W'(TIMEOUT - 1)) begin
                fin_s = 1'b1;
            end else begin
                tick_s = 1'b1;
            end
        end else begin
            tick_s = 1'b0;
        end
    end

    // Main controller: state, trace buffer and all registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r         <= ST_IDLE;
            len_r           <= {LEN_W{1'b0}};
            ptr_r           <= {LEN_W{1'b0}};
            visited_r       <= {PROC_NUM{1'b0}};
            origin_r        <= {ID_W{1'b0}};
            tcnt_r          <= {CNT_W{1'b0}};
            first_r         <= 1'b0;
            dl_detect_in    <= 1'b0;
            origin_vec      <= {PROC_NUM{1'b0}};
            token_clear_vec <= {PROC_NUM{1'b0}};
            deadlock        <= 1'b0;
            trace_closed    <= 1'b0;
            rpt_valid       <= 1'b0;
            rpt_data        <= {ID_W{1'b0}};
            rpt_last        <= 1'b0;
            for (int i = 0; i < BUF_N; i++) begin
                trace_r[i] <= {ID_W{1'b0}};
            end
        end else begin
            origin_vec      <= {PROC_NUM{1'b0}};
            token_clear_vec <= {PROC_NUM{1'b0}};
            case (state_r)
                ST_IDLE: begin
                    if (dl_detect_vec != {PROC_NUM{1'b0}}) begin
                        origin_r     <= lowest_idx(dl_detect_vec);
                        origin_vec   <= onehot(lowest_idx(dl_detect_vec));
                        dl_detect_in <= 1'b1;
                        deadlock     <= 1'b1;
                        state_r      <= ST_ORIGIN;
                    end
                end
                ST_ORIGIN: begin
                    trace_r[0] <= origin_r;
                    len_r      <= LEN_W'(1);
                    visited_r  <= onehot(origin_r);
                    tcnt_r     <= {CNT_W{1'b0}};
                    first_r    <= 1'b1;
                    state_r    <= ST_TRACE;
                end
                ST_TRACE: begin
                    first_r <= 1'b0;
                    if (fin_s) begin
                        token_clear_vec <= {PROC_NUM{1'b1}};
                        trace_closed    <= fin_closed_s;
                        rpt_valid       <= 1'b1;
                        rpt_data        <= trace_r[0];
                        rpt_last        <= (len_r == LEN_W'(1));
                        ptr_r           <= {LEN_W{1'b0}};
                        state_r         <= ST_REPORT;
                    end else if (app_s) begin
                        trace_r[ID_W'(len_r)] <= new_idx_s;
                        len_r                 <= len_r + LEN_W'(1);
                        visited_r             <= visited_r | onehot(new_idx_s);
                        tcnt_r                <= {CNT_W{1'b0}};
                    end else if (tick_s) begin
                        tcnt_r <= tcnt_r + CNT_W'(1);
                    end
                end
                ST_REPORT: begin
                    if (rpt_ready) begin
                        if (rpt_last) begin
                            rpt_valid <= 1'b0;
                            rpt_last  <= 1'b0;
                            state_r   <= ST_DONE;
                        end else begin
                            ptr_r    <= ptr_r + LEN_W'(1);
                            rpt_data <= trace_r[ID_W'(ptr_r + LEN_W'(1))];
                            rpt_last <= ((ptr_r + LEN_W'(2)) == len_r);
                        end
                    end
                end
                ST_DONE: begin
                    state_r <= ST_DONE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_test_hu_hls_deadlock_report_unit.sv
// Self-checking bench for test_hu_hls_deadlock_report_unit: a queue-based
// model of the trace/report behaviour is compared with the DUT every cycle,
// and each scenario is also pinned with hand-computed literal expectations.
module tb_test_hu_hls_deadlock_report_unit;

    localparam int PN = 4;
    localparam int IW = 2;
    localparam int TO = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [PN-1:0] dl_detect_vec = '0;
    logic [PN-1:0] proc_token_vec = '0;
    logic          rpt_ready = 1'b0;
    logic          dl_detect_in;
    logic [PN-1:0] origin_vec;
    logic [PN-1:0] token_clear_vec;
    logic          deadlock;
    logic          trace_closed;
    logic          rpt_valid;
    logic [IW-1:0] rpt_data;
    logic          rpt_last;

    test_hu_hls_deadlock_report_unit #(.PROC_NUM(PN), .ID_W(IW), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset),
        .dl_detect_vec(dl_detect_vec), .proc_token_vec(proc_token_vec),
        .dl_detect_in(dl_detect_in), .origin_vec(origin_vec),
        .token_clear_vec(token_clear_vec), .deadlock(deadlock),
        .trace_closed(trace_closed), .rpt_valid(rpt_valid),
        .rpt_ready(rpt_ready), .rpt_data(rpt_data), .rpt_last(rpt_last)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    function automatic int lowest(input logic [PN-1:0] v);
        for (int i = 0; i < PN; i++) if (v[i]) return i;
        return -1;
    endfunction

    // ---------------- behavioural model ----------------
    localparam int P_IDLE = 0, P_ORIGIN = 1, P_TRACE = 2, P_REPORT = 3, P_DONE = 4;
    int phase, m_origin, m_idle, fresh;
    bit m_first, seen;
    int q[$];
    int rq[$];
    int exp_det, exp_origin, exp_clear, exp_closed, exp_valid, exp_data, exp_last;

    task automatic close_trace(input int closed);
        exp_clear  = 4'hF;
        exp_closed = closed;
        rq         = q;
        exp_valid  = 1;
        phase      = P_REPORT;
    endtask

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            phase = P_IDLE; q.delete(); rq.delete();
            exp_det = 0; exp_origin = 0; exp_clear = 0; exp_closed = 0;
            exp_valid = 0; exp_data = 0; exp_last = 0;
        end else begin
            exp_origin = 0;
            exp_clear  = 0;
            case (phase)
                P_IDLE: if (dl_detect_vec != 0) begin
                    m_origin   = lowest(dl_detect_vec);
                    exp_det    = 1;
                    exp_origin = 1 << m_origin;
                    phase      = P_ORIGIN;
                end
                P_ORIGIN: begin
                    q.delete(); q.push_back(m_origin);
                    m_first = 1; m_idle = 0; phase = P_TRACE;
                end
                P_TRACE: begin
                    fresh = -1;
                    for (int i = PN - 1; i >= 0; i--) begin
                        seen = 0;
                        for (int k = 0; k < q.size(); k++) if (q[k] == i) seen = 1;
                        if (proc_token_vec[i] && !seen) fresh = i;
                    end
                    if (proc_token_vec[m_origin] && !m_first) close_trace(1);
                    else if (fresh >= 0) begin
                        if (q.size() == PN) close_trace(0);
                        else begin q.push_back(fresh); m_idle = 0; end
                    end else if (proc_token_vec == 0) begin
                        m_idle++;
                        if (m_idle == TO) close_trace(0);
                    end
                    m_first = 0;
                end
                P_REPORT: if (rpt_ready) begin
                    void'(rq.pop_front());
                    if (rq.size() == 0) begin exp_valid = 0; phase = P_DONE; end
                end
                default: ;
            endcase
            if (phase == P_REPORT) begin
                exp_data = rq[0];
                exp_last = (rq.size() == 1) ? 1 : 0;
            end else begin
                exp_last = 0;
            end
        end
    end

    // ---------------- compare process and logs ----------------
    int  xfer_log[$];
    int  clr_cnt, clr_val, org_cnt, org_val;
    bit  prev_stall;
    int  prev_data, prev_last;

    always @(negedge clock) begin
        chk("deadlock", deadlock, exp_det);
        chk("dl_detect_in", dl_detect_in, exp_det);
        chk("origin_vec", origin_vec, exp_origin);
        chk("token_clear_vec", token_clear_vec, exp_clear);
        chk("trace_closed", trace_closed, exp_closed);
        chk("rpt_valid", rpt_valid, exp_valid);
        if (exp_valid != 0) begin
            chk("rpt_data", rpt_data, exp_data);
            chk("rpt_last", rpt_last, exp_last);
        end
        if (prev_stall && reset) begin
            chk("stall_data", rpt_data, prev_data);
            chk("stall_last", rpt_last, prev_last);
        end
        prev_stall = rpt_valid && !rpt_ready && reset;
        prev_data  = rpt_data;
        prev_last  = rpt_last;
        if (rpt_valid && rpt_ready) xfer_log.push_back(int'(rpt_data));
        if (token_clear_vec != 0) begin clr_cnt++; clr_val = token_clear_vec; end
        if (origin_vec != 0) begin org_cnt++; org_val = origin_vec; end
    end

    function automatic int log_at(input int i);
        if (i < xfer_log.size()) return xfer_log[i];
        return -1;
    endfunction

    // ---------------- stimulus ----------------
    task automatic cyc(input logic [PN-1:0] det, input logic [PN-1:0] tok, input logic rdy);
        dl_detect_vec = det; proc_token_vec = tok; rpt_ready = rdy;
        @(posedge clock); #1;
    endtask

    task automatic do_reset(input string tag);
        #2 reset = 1'b0;
        #1 chk({tag, "_outs_zero"},
               {dl_detect_in, origin_vec, token_clear_vec, deadlock, trace_closed,
                rpt_valid, rpt_data, rpt_last}, 0);
        dl_detect_vec = '0; proc_token_vec = '0; rpt_ready = 1'b0;
        xfer_log.delete(); clr_cnt = 0; clr_val = 0; org_cnt = 0; org_val = 0;
        @(posedge clock); #1 reset = 1'b1;
    endtask

    task automatic drain(input int n);
        repeat (n) cyc('0, '0, 1'b1);
    endtask

    initial begin
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1 chk("reset_outs_zero",
               {dl_detect_in, origin_vec, token_clear_vec, deadlock, trace_closed,
                rpt_valid, rpt_data, rpt_last}, 0);
        reset = 1'b1;
        cyc('0, '0, 1'b1);

        // 3-process loop: origin 2, tokens at 1, 0, then back at 2
        cyc(4'b0100, 4'b0000, 1'b1);
        cyc(4'b0000, 4'b0000, 1'b1);
        cyc(4'b0000, 4'b0010, 1'b1);
        cyc(4'b0000, 4'b0001, 1'b1);
        cyc(4'b0000, 4'b0100, 1'b1);
        chk("t1_clear_now", token_clear_vec, 4'hF);
        chk("t1_valid_now", rpt_valid, 1);
        drain(6);
        chk("t1_org_cnt", org_cnt, 1);
        chk("t1_org_val", org_val, 4'b0100);
        chk("t1_len", xfer_log.size(), 3);
        chk("t1_e0", log_at(0), 2);
        chk("t1_e1", log_at(1), 1);
        chk("t1_e2", log_at(2), 0);
        chk("t1_closed", trace_closed, 1);
        chk("t1_clr_cnt", clr_cnt, 1);
        chk("t1_clr_val", clr_val, 4'hF);
        chk("t1_deadlock", deadlock, 1);

        // Simultaneous detect, later detections ignored
        do_reset("t2");
        cyc(4'b1010, 4'b0000, 1'b1);
        cyc(4'b1000, 4'b0000, 1'b1);
        cyc(4'b1000, 4'b0100, 1'b1);
        cyc(4'b1000, 4'b0010, 1'b1);
        drain(5);
        chk("t2_org_cnt", org_cnt, 1);
        chk("t2_org_val", org_val, 4'b0010);
        chk("t2_len", xfer_log.size(), 2);
        chk("t2_e0", log_at(0), 1);
        chk("t2_e1", log_at(1), 2);

        // Timeout: origin 0, no tokens anywhere
        do_reset("t3");
        cyc(4'b0001, 4'b0000, 1'b1);
        cyc(4'b0000, 4'b0000, 1'b1);
        repeat (15) cyc('0, '0, 1'b1);
        chk("t3_no_clear_15", token_clear_vec, 0);
        cyc('0, '0, 1'b1);
        chk("t3_clear_16", token_clear_vec, 4'hF);
        chk("t3_last_now", rpt_last, 1);
        drain(4);
        chk("t3_len", xfer_log.size(), 1);
        chk("t3_e0", log_at(0), 0);
        chk("t3_closed", trace_closed, 0);
        chk("t3_deadlock", deadlock, 1);

        // Backpressure on a 4-entry report
        do_reset("t4");
        cyc(4'b0001, 4'b0000, 1'b1);
        cyc(4'b0000, 4'b0000, 1'b1);
        cyc(4'b0000, 4'b0010, 1'b1);
        cyc(4'b0000, 4'b0100, 1'b1);
        cyc(4'b0000, 4'b1000, 1'b1);
        cyc(4'b0000, 4'b0001, 1'b1);
        for (int k = 0; k < 16; k++) cyc('0, '0, ((k % 4) == 0 || (k % 4) == 3) ? 1'b1 : 1'b0);
        chk("t4_len", xfer_log.size(), 4);
        for (int k = 0; k < 4; k++) chk("t4_entry", log_at(k), k);
        chk("t4_closed", trace_closed, 1);
        chk("t4_valid_done", rpt_valid, 0);

        // Reset mid-TRACE after two appends, then restart
        do_reset("t5a");
        cyc(4'b0001, 4'b0000, 1'b1);
        cyc(4'b0000, 4'b0000, 1'b1);
        cyc(4'b0000, 4'b0010, 1'b1);
        cyc(4'b0000, 4'b0100, 1'b1);
        do_reset("t5_mid");
        cyc(4'b1000, 4'b0000, 1'b1);
        cyc(4'b0000, 4'b0000, 1'b1);
        cyc(4'b0000, 4'b1000, 1'b1);
        cyc(4'b0000, 4'b1000, 1'b1);
        drain(4);
        chk("t5_org_val", org_val, 4'b1000);
        chk("t5_len", xfer_log.size(), 1);
        chk("t5_e0", log_at(0), 3);
        chk("t5_closed", trace_closed, 1);

        // Revisit: token lingers at process 1 for three cycles
        do_reset("t6");
        cyc(4'b0001, 4'b0000, 1'b1);
        cyc(4'b0000, 4'b0000, 1'b1);
        repeat (3) cyc(4'b0000, 4'b0010, 1'b1);
        cyc(4'b0000, 4'b0001, 1'b1);
        drain(5);
        chk("t6_len", xfer_log.size(), 2);
        chk("t6_e0", log_at(0), 0);
        chk("t6_e1", log_at(1), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
